// File: rtl/rgmii_rx_fifo_sched_if.sv
// RGMII receive FIFO read bus plus framed byte stream towards the MAC.
// Ports: fifo_empty/fifo_prog_empty/fifo_dout in, fifo_rd_en out; out_* stream.
interface rgmii_rx_fifo_sched_if;
    logic       fifo_empty;
    logic       fifo_prog_empty;
    logic [8:0] fifo_dout;
    logic       fifo_rd_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sof;
    logic       out_eof;
    logic       out_err;

    modport master (
        input  fifo_empty, fifo_prog_empty, fifo_dout,
        output fifo_rd_en, out_data, out_valid, out_sof, out_eof, out_err
    );

    modport slave (
        output fifo_empty, fifo_prog_empty, fifo_dout,
        input  fifo_rd_en, out_data, out_valid, out_sof, out_eof, out_err
    );
endinterface

// File: rtl/rgmii_rx_fifo_sched.sv
// Read-side scheduler for the RGMII RX CDC FIFO: fill hold, contiguous drain,
// framed byte stream with sof/eof/err, inter-frame gap and frame statistics.
// Ports: clk125MHz, rst_n (async, active low), link_up, bus (FIFO read side
// and out_* stream, master modport), frame_count, err_count.
// Optional: define RX_PREAMBLE_STRIP_EN to drop preamble and SFD bytes.
module rgmii_rx_fifo_sched #(
    parameter int GAP_CYCLES = 12,
    parameter int MAX_FRAME  = 1530,
    parameter int CNT_W      = 16
) (
    input  logic                     clk125MHz,
    input  logic                     rst_n,
    input  logic                     link_up,
    rgmii_rx_fifo_sched_if.master    bus,
    output logic [CNT_W-1:0]         frame_count,
    output logic [CNT_W-1:0]         err_count
);
    localparam int BC_W = $clog2(MAX_FRAME + 1);
    localparam int GC_W = $clog2(GAP_CYCLES + 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(MAX_FRAME - 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_STREAM, S_DISCARD, S_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        hreg_q, hreg_d;
    logic              hvld_q, hvld_d;
    logic              first_q, first_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [GC_W-1:0]   gcnt_q, gcnt_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sof_q, out_sof_d;
    logic              out_eof_q, out_eof_d;
    logic              out_err_q, out_err_d;
    logic [CNT_W-1:0]  frm_q, frm_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              frm_inc, err_inc;
    logic              rd_en;
    logic              en;
    logic [7:0]        din;
`ifdef RX_PREAMBLE_STRIP_EN
    logic              pre_q, pre_d;
    logic [2:0]        pcnt_q, pcnt_d;
`endif

    assign en  = bus.fifo_dout[8];
    assign din = bus.fifo_dout[7:0];

    always_comb begin
        state_d     = state_q;
        hreg_d      = hreg_q;
        hvld_d      = hvld_q;
        first_d     = first_q;
        bcnt_d      = bcnt_q;
        gcnt_d      = gcnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        out_err_d   = 1'b0;
        frm_inc     = 1'b0;
        err_inc     = 1'b0;
        rd_en       = 1'b0;
`ifdef RX_PREAMBLE_STRIP_EN
        pre_d       = pre_q;
        pcnt_d      = pcnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!link_up) begin
                    rd_en = !bus.fifo_empty;
                end else if (!bus.fifo_empty) begin
                    if (!en) rd_en = 1'b1;
                    else     state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (!link_up) begin
                    state_d = S_IDLE;
                end else if (!bus.fifo_prog_empty) begin
                    state_d = S_STREAM;
                    hvld_d  = 1'b0;
`ifdef RX_PREAMBLE_STRIP_EN
                    pre_d   = 1'b1;
                    pcnt_d  = 3'd0;
`endif
                end
            end
            S_STREAM: begin
                if (!link_up || (bus.fifo_empty && hvld_q)) begin
                    // Underflow or link loss: close the frame on the held byte.
                    if (hvld_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = hreg_q;
                        out_sof_d   = first_q;
                        out_eof_d   = 1'b1;
                        out_err_d   = 1'b1;
                        err_inc     = 1'b1;
                    end
                    hvld_d  = 1'b0;
                    state_d = S_DISCARD;
                end else if (!bus.fifo_empty) begin
                    rd_en = 1'b1;
`ifdef RX_PREAMBLE_STRIP_EN
                    if (pre_q) begin
                        if (!en) begin
                            err_inc = 1'b1;
                            state_d = S_GAP;
                        end else if (din == 8'hD5) begin
                            pre_d = 1'b0;
                        end else if (din == 8'h55 && pcnt_q != 3'd7) begin
                            pcnt_d = pcnt_q + 3'd1;
                        end else begin
                            err_inc = 1'b1;
                            state_d = S_DISCARD;
                        end
                    end else
`endif
                    if (!en) begin
                        if (hvld_q) begin
                            out_valid_d = 1'b1;
                            out_data_d  = hreg_q;
                            out_sof_d   = first_q;
                            out_eof_d   = 1'b1;
                            frm_inc     = 1'b1;
                        end
                        hvld_d  = 1'b0;
                        state_d = S_GAP;
                    end else if (!hvld_q) begin
                        hreg_d  = din;
                        hvld_d  = 1'b1;
                        first_d = 1'b1;
                        bcnt_d  = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = hreg_q;
                        out_sof_d   = first_q;
                        first_d     = 1'b0;
                        hreg_d      = din;
                        bcnt_d      = bcnt_q + 1'b1;
                        // Another byte follows the limit byte: truncate.
                        if (bcnt_q == BC_LAST) begin
                            out_eof_d = 1'b1;
                            out_err_d = 1'b1;
                            err_inc   = 1'b1;
                            hvld_d    = 1'b0;
                            state_d   = S_DISCARD;
                        end
                    end
                end
            end
            S_DISCARD: begin
                rd_en = !bus.fifo_empty;
                if (!bus.fifo_empty && !en) state_d = S_GAP;
            end
            S_GAP: begin
                // A waiting en=1 word stays in the FIFO for IDLE.
                rd_en  = !bus.fifo_empty && !en;
                gcnt_d = gcnt_q + 1'b1;
                if (gcnt_q == GC_LAST) begin
                    gcnt_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        frm_d = frm_q;
        err_d = err_q;
        if (frm_inc && frm_q != {CNT_W{1'b1}}) frm_d = frm_q + 1'b1;
        if (err_inc && err_q != {CNT_W{1'b1}}) err_d = err_q + 1'b1;
    end

    always_ff @(posedge clk125MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hreg_q      <= '0;
            hvld_q      <= 1'b0;
            first_q     <= 1'b0;
            bcnt_q      <= '0;
            gcnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_err_q   <= 1'b0;
            frm_q       <= '0;
            err_q       <= '0;
`ifdef RX_PREAMBLE_STRIP_EN
            pre_q       <= 1'b0;
            pcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hreg_q      <= hreg_d;
            hvld_q      <= hvld_d;
            first_q     <= first_d;
            bcnt_q      <= bcnt_d;
            gcnt_q      <= gcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_err_q   <= out_err_d;
            frm_q       <= frm_d;
            err_q       <= err_d;
`ifdef RX_PREAMBLE_STRIP_EN
            pre_q       <= pre_d;
            pcnt_q      <= pcnt_d;
`endif
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sof    = out_sof_q;
    assign bus.out_eof    = out_eof_q;
    assign bus.out_err    = out_err_q;
    assign frame_count    = frm_q;
    assign err_count      = err_q;
endmodule

// File: tb/tb_rgmii_rx_fifo_sched.sv
// Self-checking bench for rgmii_rx_fifo_sched: FWFT FIFO model feeding the
// DUT, scoreboard of expected output beats, directed frame scenarios.
module tb_rgmii_rx_fifo_sched;
    localparam int GAP    = 12;
    localparam int THRESH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        link_up = 1'b1;
    logic [15:0] frame_count;
    logic [15:0] err_count;

    rgmii_rx_fifo_sched_if bus ();

    rgmii_rx_fifo_sched #(
        .GAP_CYCLES(GAP), .MAX_FRAME(1530), .CNT_W(16)
    ) dut (
        .clk125MHz  (clk),
        .rst_n      (rst_n),
        .link_up    (link_up),
        .bus        (bus),
        .frame_count(frame_count),
        .err_count  (err_count)
    );

    always #4 clk = ~clk;

    logic [8:0]  fifo_q[$];
    logic [10:0] exp_q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    logic        prog_force = 1'b0;
    int          uf_cnt = 0;
    logic        mark_arm = 1'b0;
    logic        mark_uf = 1'b0;
    logic        mark_hit = 1'b0;
    logic [7:0]  mark_data = 8'h00;
    int          gap_cnt = 0;
    logic        seen_eof = 1'b0;

    // FIFO model outputs change only on the falling edge.
    always @(negedge clk) begin
        bus.fifo_empty      = (fifo_q.size() == 0) || (uf_cnt > 0);
        bus.fifo_prog_empty = prog_force || (fifo_q.size() < THRESH);
        bus.fifo_dout       = (fifo_q.size() > 0) ? fifo_q[0] : 9'h000;
    end

    always @(posedge clk) begin
        logic [8:0] w;
        if (uf_cnt > 0) uf_cnt--;
        if (bus.fifo_rd_en) begin
            n_assert++;
            assert (bus.fifo_empty === 1'b0) else begin
                n_fail++;
                $error("FAIL rd_en_while_empty got=%b exp=0", bus.fifo_empty);
            end
            if (fifo_q.size() > 0) begin
                w = fifo_q.pop_front();
                if (mark_arm && w == {1'b1, mark_data}) begin
                    mark_hit = 1'b1;
                    mark_arm = 1'b0;
                    if (mark_uf) uf_cnt = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [10:0] got;
        logic [10:0] e;
        if (rst_n) begin
            n_assert++;
            assert (bus.out_valid || !(bus.out_sof || bus.out_eof || bus.out_err))
            else begin
                n_fail++;
                $error("FAIL strobe_without_valid got=%b%b%b exp=000",
                       bus.out_sof, bus.out_eof, bus.out_err);
            end
            if (bus.out_valid) begin
                got = {bus.out_data, bus.out_sof, bus.out_eof, bus.out_err};
                n_assert++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_beat got=%h exp=none", got);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_assert++;
                    assert (got === e) else begin
                        n_fail++;
                        $error("FAIL beat got=%h exp=%h", got, e);
                    end
                end
                if (bus.out_sof && seen_eof) begin
                    n_assert++;
                    assert (gap_cnt >= GAP) else begin
                        n_fail++;
                        $error("FAIL ifg got=%0d exp>=%0d", gap_cnt, GAP);
                    end
                end
                if (bus.out_eof) begin
                    seen_eof = 1'b1;
                    gap_cnt  = 0;
                end
            end else begin
                gap_cnt++;
            end
        end else begin
            seen_eof = 1'b0;
            gap_cnt  = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic en, input logic [7:0] d);
        fifo_q.push_back({en, d});
    endtask

    task automatic exp_b(input logic [7:0] d, input logic s, input logic e,
                         input logic r);
        exp_q.push_back({d, s, e, r});
    endtask

    // n bytes base+i, then one idle word; first good_n bytes expected out.
    task automatic frame_seq(input int n, input int base, input int good_n,
                             input logic err_end);
        for (int i = 0; i < n; i++) put(1'b1, 8'(base + i));
        put(1'b0, 8'h00);
        for (int i = 0; i < good_n; i++)
            exp_b(8'(base + i), i == 0, i == good_n - 1,
                  err_end && (i == good_n - 1));
    endtask

    task automatic pre_frame(input logic sfd);
        logic [7:0] b[$];
        repeat (7) b.push_back(8'h55);
        if (sfd) b.push_back(8'hD5);
        for (int i = 0; i < 60; i++) b.push_back(8'(8'hAA + i));
        foreach (b[i]) put(1'b1, b[i]);
        put(1'b0, 8'h00);
`ifdef RX_PREAMBLE_STRIP_EN
        if (sfd)
            for (int i = 0; i < 60; i++)
                exp_b(8'(8'hAA + i), i == 0, i == 59, 1'b0);
`else
        foreach (b[i]) exp_b(b[i], i == 0, i == b.size() - 1, 1'b0);
`endif
    endtask

    task automatic drain(input int budget, input string tag);
        int i = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        repeat (40) @(negedge clk);
        check({tag, "_exp_left"}, exp_q.size(), 0);
        check({tag, "_fifo_left"}, fifo_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        mark_arm   = 1'b0;
        mark_hit   = 1'b0;
        mark_uf    = 1'b0;
        uf_cnt     = 0;
        prog_force = 1'b0;
        link_up    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int i;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.out_valid, 0);
        check("rst_sof", bus.out_sof, 0);
        check("rst_eof", bus.out_eof, 0);
        check("rst_err", bus.out_err, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_frames", frame_count, 0);
        check("rst_errs", err_count, 0);
        check("rst_rd_en", bus.fifo_rd_en, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle words then one 64-byte frame.
        repeat (3) put(1'b0, 8'h00);
        frame_seq(64, 1, 64, 1'b0);
        drain(2000, "t1");
        check("t1_frames", frame_count, 1);
        check("t1_errs", err_count, 0);

        // Back-to-back frames, one idle word between.
        do_reset();
        frame_seq(64, 1, 64, 1'b0);
        frame_seq(64, 8'h41, 64, 1'b0);
        drain(2000, "t2");
        check("t2_frames", frame_count, 2);
        check("t2_errs", err_count, 0);

        // Underflow right after byte 20 is popped.
        do_reset();
        mark_data = 8'h14;
        mark_uf   = 1'b1;
        mark_arm  = 1'b1;
        frame_seq(64, 1, 20, 1'b1);
        frame_seq(64, 1, 64, 1'b0);
        drain(2000, "t3");
        check("t3_mark", mark_hit, 1);
        check("t3_frames", frame_count, 1);
        check("t3_errs", err_count, 1);

        // Oversize frame truncated at the limit byte.
        do_reset();
        frame_seq(1600, 0, 1530, 1'b1);
        frame_seq(64, 1, 64, 1'b0);
        drain(5000, "t4");
        check("t4_frames", frame_count, 1);
        check("t4_errs", err_count, 1);

        // Link loss while waiting in FILL, then in mid-stream.
        do_reset();
        prog_force = 1'b1;
        put(1'b0, 8'h00);
        frame_seq(64, 1, 0, 1'b0);
        repeat (10) @(negedge clk);
        check("t5_fill_hold", fifo_q.size(), 65);
        link_up = 1'b0;
        i = 0;
        while (fifo_q.size() != 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("t5_idle_flush", fifo_q.size(), 0);
        repeat (5) @(negedge clk);
        link_up    = 1'b1;
        prog_force = 1'b0;
        mark_data  = 8'h14;
        mark_uf    = 1'b0;
        mark_arm   = 1'b1;
        frame_seq(64, 1, 20, 1'b1);
        i = 0;
        while (!mark_hit && i < 500) begin
            @(negedge clk);
            i++;
        end
        check("t5_mark", mark_hit, 1);
        link_up = 1'b0;
        drain(1000, "t5");
        check("t5_frames", frame_count, 0);
        check("t5_errs", err_count, 1);
        link_up = 1'b1;

        // Preamble with and without SFD.
        do_reset();
        pre_frame(1'b1);
        pre_frame(1'b0);
        drain(2000, "t6");
`ifdef RX_PREAMBLE_STRIP_EN
        check("t6_frames", frame_count, 1);
        check("t6_errs", err_count, 1);
`else
        check("t6_frames", frame_count, 2);
        check("t6_errs", err_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
